pht_upd_sched: RTL and testbench
================================

# pht_upd_sched

Write scheduler for the gshare pattern history table. Two branch-resolution ports deliver resolved conditional-branch outcomes (PHT index + actual direction). The block buffers them in a small in-order FIFO and issues at most one PHT write per cycle on the predictor's single write port. It never issues two consecutive writes to the same index, so each read-modify-write of the 2-bit counter sees the previous update.

## Interface
Parameters:
- `IDX_W`, 10 — PHT index width; equals the gshare PHT entry-select width.
- `DEPTH`, 4 — FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_vld0`  in  1  port 0 resolved branch valid; port 0 is always the older branch.
- `i_idx0`  in  IDX_W  port 0 PHT index.
- `i_taken0`  in  1  port 0 actual direction (1 = taken).
- `i_vld1`  in  1  port 1 resolved branch valid.
- `i_idx1`  in  IDX_W  port 1 PHT index.
- `i_taken1`  in  1  port 1 actual direction.
- `i_pause`  in  1  suppresses write issue this cycle (PHT unavailable).
- `o_stall`  out  1  fewer than 2 free entries; upstream must not present pushes while high.
- `o_pht_wr_en`  out  1  PHT write strobe.
- `o_pht_wr_addr`  out  IDX_W  PHT write index.
- `o_jmpcond`  out  1  direction for the counter update.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.
- `o_ovf`  out  1  sticky: a push was dropped because the FIFO was full.

## Operation
State:
- FIFO storage (`idx`, `taken`) per entry.
- Write/read pointers, each $clog2(DEPTH)+1 bits with a wrap bit.
- `last_vld`, `last_idx`: the write issued in the previous cycle.
- `o_ovf`.

Enqueue:
- Both ports valid: port 0 is written at `wptr`, port 1 at `wptr+1`, and `wptr` advances by 2.
- Only one port valid: that entry is written at `wptr`, and `wptr` advances by 1.
- Only `i_vld1` valid: it still occupies a single slot.
- Space is checked against occupancy after this cycle's pop. Any push that would exceed `DEPTH` is dropped, and `o_ovf` is set.
- When both ports are valid and only one slot is free, port 0 is kept and port 1 is dropped (`o_ovf` set).

Issue (combinational from the head entry):
- `hazard = last_vld && (last_idx == head.idx)`.
- `o_pht_wr_en = !empty && !i_pause && !hazard`.
- `o_pht_wr_addr = head.idx` and `o_jmpcond = head.taken` whenever the FIFO is non-empty; 0 when empty.
- When `o_pht_wr_en` is high, `rptr` advances by 1 at the clock edge.

Last-write tracking:
- `last_vld <= o_pht_wr_en` every cycle.
- `last_idx <= o_pht_wr_addr` when `o_pht_wr_en` is high.
- A paused or hazard cycle clears `last_vld`, so the hazard bubble is exactly one cycle.

Occupancy and flags:
- `o_count = wptr - rptr` (modular).
- `empty` when `o_count == 0`.
- `o_stall = (DEPTH - o_count) < 2`.
- Pop and push in the same cycle are legal. A pop frees its slot for the same-cycle push.

Other rules:
- Ordering is strict FIFO. Entries are never reordered around a hazard.
- The block holds no predictor state; saturation arithmetic stays in the PHT owner.

## Timing
- Reset (asynchronous assert): pointers = 0, `last_vld` = 0, `last_idx` = 0, `o_ovf` = 0.
  - Outputs in reset: `o_pht_wr_en` = 0, `o_pht_wr_addr` = 0, `o_jmpcond` = 0, `o_count` = 0, `o_stall` = 0.
- Reset deassertion mid-operation: the FIFO content is discarded, and the first write can issue no earlier than the cycle after the first push.
- Latency: a push at edge t makes the entry visible at the head in cycle t+1. `o_pht_wr_en` can be high in cycle t+1 if the FIFO was empty.
- Throughput: 1 write/cycle, except one bubble per same-index back-to-back pair.
- `i_pause` only gates issue. Enqueue continues, and `o_stall` is updated normally.
- Wrap-around: pointers wrap modulo 2·`DEPTH`. Full is indicated by equal index bits with differing wrap bits.

## Test plan
- Reset, then a single push `idx0=0x12A, taken0=1` at cycle 0 → cycle 1: `o_pht_wr_en=1`, addr 0x12A, jmpcond 1; cycle 2: `o_count=0`, `o_pht_wr_en=0`.
- Same-cycle push port0 `0x005/0`, port1 `0x3FF/1` → writes 0x005 (cycle 1) then 0x3FF (cycle 2), in that order.
- Push port0 `0x040/1`, port1 `0x040/0` → write 0x040/1 in cycle 1, bubble in cycle 2, write 0x040/0 in cycle 3.
- Hold `i_pause=1` while pushing 2 entries/cycle for 2 cycles (DEPTH=4) → `o_count=4`, `o_stall=1`. Pushing 2 more with `i_pause` still high → both dropped, `o_ovf=1` and sticky; the 4 original entries drain in order after pause release.
- Run 10 mixed pushes with continuous drain, covering pointer wrap → the write sequence matches the push order exactly, and `o_count` returns to 0.
- Assert `rst` asynchronously mid-drain with 3 entries queued → `o_pht_wr_en` and `o_count` drop to 0 immediately, without waiting for a clock edge; after release no stale write issues.

Source files
------------

// File: rtl/pht_upd_sched.sv
// PHT write scheduler: two-port in-order enqueue of resolved branches, one PHT
// write per cycle, with a one-cycle bubble between back-to-back same-index writes.
module pht_upd_sched #(
  parameter int IDX_W = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_vld0,
  input  logic [IDX_W-1:0]           i_idx0,
  input  logic                       i_taken0,
  input  logic                       i_vld1,
  input  logic [IDX_W-1:0]           i_idx1,
  input  logic                       i_taken1,
  input  logic                       i_pause,
  output logic                       o_stall,
  output logic                       o_pht_wr_en,
  output logic [IDX_W-1:0]           o_pht_wr_addr,
  output logic                       o_jmpcond,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [IDX_W-1:0] idx_mem_q [DEPTH];
  logic [DEPTH-1:0] taken_mem_q;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             last_vld_q;
  logic [IDX_W-1:0] last_idx_q;
  logic             ovf_q, ovf_d;

  logic [PW-1:0]    count;
  logic [PW-1:0]    occ_after_pop;
  logic [PW-1:0]    free_after_pop;
  logic             empty;
  logic             hazard;
  logic             pop;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic             we0, we1;
  logic             sel1_p0;
  logic [AW-1:0]    slot1;

  always_comb begin
    count      = wptr_q - rptr_q;
    empty      = (count == '0);
    head_idx   = idx_mem_q[rptr_q[AW-1:0]];
    head_taken = taken_mem_q[rptr_q[AW-1:0]];
    hazard     = last_vld_q && (last_idx_q == head_idx);
    pop        = !empty && !i_pause && !hazard;
    rptr_d     = rptr_q + PW'(pop);

    // A same-cycle pop frees its slot for this cycle's push.
    occ_after_pop  = count - PW'(pop);
    free_after_pop = PW'(DEPTH) - occ_after_pop;

    we0     = 1'b0;
    we1     = 1'b0;
    sel1_p0 = 1'b0;
    wptr_d  = wptr_q;
    ovf_d   = ovf_q;
    if (i_vld0 && i_vld1) begin
      if (free_after_pop >= PW'(2)) begin
        we0    = 1'b1;
        we1    = 1'b1;
        wptr_d = wptr_q + PW'(2);
      end else if (free_after_pop != '0) begin
        we0    = 1'b1;
        wptr_d = wptr_q + PW'(1);
        ovf_d  = 1'b1;
      end else begin
        ovf_d  = 1'b1;
      end
    end else if (i_vld0) begin
      if (free_after_pop != '0) begin
        we0    = 1'b1;
        wptr_d = wptr_q + PW'(1);
      end else begin
        ovf_d  = 1'b1;
      end
    end else if (i_vld1) begin
      if (free_after_pop != '0) begin
        we1    = 1'b1;
        wptr_d = wptr_q + PW'(1);
      end else begin
        ovf_d  = 1'b1;
      end
    end
    sel1_p0 = we0;
    slot1   = wptr_q[AW-1:0] + AW'(sel1_p0);
  end

  assign o_pht_wr_en   = pop;
  assign o_pht_wr_addr = empty ? '0 : head_idx;
  assign o_jmpcond     = empty ? 1'b0 : head_taken;
  assign o_count       = count;
  assign o_stall       = (count > PW'(DEPTH - 2));
  assign o_ovf         = ovf_q;

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (we0) begin
      idx_mem_q[wptr_q[AW-1:0]]   <= i_idx0;
      taken_mem_q[wptr_q[AW-1:0]] <= i_taken0;
    end
    if (we1) begin
      idx_mem_q[slot1]   <= i_idx1;
      taken_mem_q[slot1] <= i_taken1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      last_vld_q <= 1'b0;
      last_idx_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      last_vld_q <= pop;
      if (pop) last_idx_q <= head_idx;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pht_upd_sched.sv
// Bench for pht_upd_sched: queue-based reference model feeding a write scoreboard.
module tb_pht_upd_sched;

  localparam int IDX_W = 10;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_vld0, i_taken0, i_vld1, i_taken1, i_pause;
  logic [IDX_W-1:0] i_idx0, i_idx1;
  logic             o_stall, o_pht_wr_en, o_jmpcond, o_ovf;
  logic [IDX_W-1:0] o_pht_wr_addr;
  logic [$clog2(DEPTH):0] o_count;

  pht_upd_sched #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_vld0(i_vld0), .i_idx0(i_idx0), .i_taken0(i_taken0),
    .i_vld1(i_vld1), .i_idx1(i_idx1), .i_taken1(i_taken1),
    .i_pause(i_pause), .o_stall(o_stall), .o_pht_wr_en(o_pht_wr_en),
    .o_pht_wr_addr(o_pht_wr_addr), .o_jmpcond(o_jmpcond),
    .o_count(o_count), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             tk;
    int               cyc;
  } ent_t;

  ent_t             mq[$];
  ent_t             exp_q[$];
  bit               mlast_vld;
  logic [IDX_W-1:0] mlast_idx;
  bit               movf;
  int               cyc = 0;
  int               compared = 0;
  int               mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", nm, cyc, act, req);
    end
  endtask

  // Model: head issues unless paused or it matches the index written last cycle;
  // pushes are accepted in port order while the queue (after that pop) has room.
  task automatic cycle(input bit v0, input logic [IDX_W-1:0] x0, input bit t0,
                       input bit v1, input logic [IDX_W-1:0] x1, input bit t1,
                       input bit p);
    ent_t e;
    @(posedge clk);
    #1;
    cyc++;
    chk("count", 32'(o_count), 32'(mq.size()));
    chk("stall", 32'(o_stall), 32'((DEPTH - mq.size()) < 2));
    chk("ovf", 32'(o_ovf), 32'(movf));
    if (mq.size() == 0) begin
      chk("addr_empty", 32'(o_pht_wr_addr), 32'd0);
      chk("jmp_empty", 32'(o_jmpcond), 32'd0);
    end
    if (mq.size() > 0 && !p && !(mlast_vld && mlast_idx == mq[0].idx)) begin
      e = mq.pop_front();
      e.cyc = cyc;
      exp_q.push_back(e);
      mlast_vld = 1'b1;
      mlast_idx = e.idx;
    end else begin
      mlast_vld = 1'b0;
    end
    if (v0) begin
      if (mq.size() < DEPTH) begin e.idx = x0; e.tk = t0; e.cyc = 0; mq.push_back(e); end
      else movf = 1'b1;
    end
    if (v1) begin
      if (mq.size() < DEPTH) begin e.idx = x1; e.tk = t1; e.cyc = 0; mq.push_back(e); end
      else movf = 1'b1;
    end
    i_vld0 = v0; i_idx0 = x0; i_taken0 = t0;
    i_vld1 = v1; i_idx1 = x1; i_taken1 = t1;
    i_pause = p;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, '0, 0, 0, '0, 0, 0);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    mlast_vld = 1'b0;
    mlast_idx = '0;
    movf = 1'b0;
  endtask

  // Monitor: every write must match the oldest scoreboard entry and its cycle.
  ent_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      me = exp_q.pop_front();
      chk("wr_en", 32'(o_pht_wr_en), 32'd1);
      if (o_pht_wr_en) begin
        chk("wr_addr", 32'(o_pht_wr_addr), 32'(me.idx));
        chk("jmpcond", 32'(o_jmpcond), 32'(me.tk));
      end
    end else begin
      chk("wr_en_idle", 32'(o_pht_wr_en), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v0, v1, t0, t1, p;
    logic [IDX_W-1:0] x0, x1;
    rst = 1'b1;
    i_vld0 = 0; i_idx0 = '0; i_taken0 = 0;
    i_vld1 = 0; i_idx1 = '0; i_taken1 = 0;
    i_pause = 0;
    model_reset();
    #12;
    chk("rst_wr_en", 32'(o_pht_wr_en), 32'd0);
    chk("rst_addr", 32'(o_pht_wr_addr), 32'd0);
    chk("rst_jmp", 32'(o_jmpcond), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_ovf", 32'(o_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single push, then two-port pair, then same-index pair (bubble)
    cycle(1, 10'h12A, 1, 0, '0, 0, 0);
    idle(3);
    cycle(1, 10'h005, 0, 1, 10'h3FF, 1, 0);
    idle(3);
    cycle(1, 10'h040, 1, 1, 10'h040, 0, 0);
    idle(4);

    // Fill under pause, overflow, then drain
    cycle(1, 10'h001, 1, 1, 10'h002, 0, 1);
    cycle(1, 10'h003, 1, 1, 10'h004, 1, 1);
    cycle(1, 10'h0AA, 0, 1, 10'h0BB, 1, 1);
    cycle(0, '0, 0, 0, '0, 0, 1);
    cycle(0, '0, 0, 1, 10'h0CC, 0, 1);
    idle(7);

    // Ten mixed pushes with continuous drain across pointer wrap
    for (int k = 0; k < 10; k++) begin
      if (k % 3 == 2) cycle(1, 10'(k * 37), k[0], 1, 10'(k * 37 + 5), ~k[0], 0);
      else if (k % 3 == 1) cycle(0, '0, 0, 1, 10'(k * 91), k[1], 0);
      else cycle(1, 10'(k * 13 + 1), k[1], 0, '0, 0, 0);
    end
    idle(8);

    // Asynchronous reset mid-drain with three entries queued
    cycle(1, 10'h111, 1, 1, 10'h222, 0, 1);
    cycle(1, 10'h333, 1, 0, '0, 0, 1);
    cycle(0, '0, 0, 0, '0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_wr_en", 32'(o_pht_wr_en), 32'd0);
    chk("async_count", 32'(o_count), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Randomized traffic, small index range to provoke hazards
    for (int k = 0; k < 600; k++) begin
      v0 = ($urandom_range(0, 99) < 55);
      v1 = ($urandom_range(0, 99) < 40);
      if ((DEPTH - mq.size()) < 2 && $urandom_range(0, 3) != 0) begin
        v0 = 0; v1 = 0;
      end
      x0 = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 5));
      x1 = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 5));
      t0 = 1'($urandom);
      t1 = 1'($urandom);
      p  = ($urandom_range(0, 99) < 20);
      cycle(v0, x0, t0, v1, x1, t1, p);
    end
    idle(12);
    chk("final_count", 32'(o_count), 32'd0);
    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
